// File: rtl/light_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : light_timer
// Brief    : Per-phase countdown timer for a traffic-light controller.
//            A prescaler divides sys_clk to a 1 s tick. The phase duration
//            (green/yellow/red) counts down on each tick, and expiry of the
//            phase is flagged with a single-cycle pulse. The timer reloads
//            and repeats until the FSM selects a different phase.
// Revision : 1.0 - initial release
// ============================================================================
module light_timer #(
    parameter int          CLK_DIV = 50_000_000,  // sys_clk cycles per 1 s tick (>= 2)
    parameter logic [3:0]  G_T     = 4'd10,       // green duration, seconds
    parameter logic [3:0]  Y_T     = 4'd5,        // yellow duration, seconds
    parameter logic [3:0]  R_T     = 4'd15        // red duration, seconds
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,    // synchronous, active-high despite the name
    input  logic [2:0]  light_ctrl,
    input  logic        timer_en,
    output logic        sys_clk_1s,
    output logic [3:0]  light_t,
    output logic        phase_done
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [PW-1:0] C_PRESC_MAX  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] C_PRESC_ZERO = '0;
    localparam logic [PW-1:0] C_PRESC_ONE  = PW'(1);

    localparam logic [2:0] C_CTRL_IDLE = 3'b000;
    localparam logic [2:0] C_CTRL_G    = 3'b001;
    localparam logic [2:0] C_CTRL_Y    = 3'b010;
    localparam logic [2:0] C_CTRL_R    = 3'b100;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    // Duration for a normalised phase code. IDLE maps to 1 so the FSM sees
    // an expiry on every tick; a zero-length parameter is stretched to 1 so
    // the countdown never reaches 0.
    function automatic logic [3:0] f_duration(input logic [2:0] code);
        logic [3:0] v;
        case (code)
            C_CTRL_G: v = G_T;
            C_CTRL_Y: v = Y_T;
            C_CTRL_R: v = R_T;
            default:  v = 4'd1;
        endcase
        if (v == 4'd0) begin
            v = 4'd1;
        end
        return v;
    endfunction

    // ------------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------------
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_nxt;
    logic [2:0]    r_ctrl;
    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [3:0]    r_light;
    logic [3:0]    w_light_nxt;
    logic          r_tick;
    logic          r_done;
    logic          w_done_nxt;

    logic [2:0]    w_ctrl_norm;
    logic          w_change;
    logic          w_tick;

    // Collapse illegal phase codes onto IDLE and detect a phase change.
    always_comb begin
        case (light_ctrl)
            C_CTRL_G: w_ctrl_norm = C_CTRL_G;
            C_CTRL_Y: w_ctrl_norm = C_CTRL_Y;
            C_CTRL_R: w_ctrl_norm = C_CTRL_R;
            default:  w_ctrl_norm = C_CTRL_IDLE;
        endcase
        w_change = (w_ctrl_norm != r_ctrl);
        w_tick   = timer_en && (r_presc == C_PRESC_MAX);
    end

    // Prescaler: counts while enabled, wraps at the tick, restarts on a phase change.
    always_comb begin
        w_presc_nxt = r_presc;
        if (w_change) begin
            w_presc_nxt = C_PRESC_ZERO;
        end else if (timer_en) begin
            w_presc_nxt = w_tick ? C_PRESC_ZERO : (r_presc + C_PRESC_ONE);
        end
    end

    // Phase FSM: IDLE whenever no valid phase is requested, otherwise RUN/PAUSE follows timer_en.
    always_comb begin
        w_state_nxt = r_state;
        if (w_ctrl_norm == C_CTRL_IDLE) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_nxt = timer_en ? ST_RUN : ST_IDLE;
                ST_RUN:   w_state_nxt = timer_en ? ST_RUN : ST_PAUSE;
                ST_PAUSE: w_state_nxt = timer_en ? ST_RUN : ST_PAUSE;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Countdown: a phase change loads the new duration and overrides any
    // same-cycle tick; otherwise a tick decrements, or at 1 (or in IDLE)
    // flags expiry and reloads the current phase.
    always_comb begin
        w_light_nxt = r_light;
        w_done_nxt  = 1'b0;
        if (w_change) begin
            w_light_nxt = f_duration(w_ctrl_norm);
        end else if (w_tick) begin
            if ((r_state == ST_RUN) && (r_light > 4'd1)) begin
                w_light_nxt = r_light - 4'd1;
            end else begin
                w_done_nxt  = 1'b1;
                w_light_nxt = f_duration(r_ctrl);
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst_n) begin
            r_presc <= C_PRESC_ZERO;
            r_ctrl  <= C_CTRL_IDLE;
            r_state <= ST_IDLE;
            r_light <= 4'd1;
            r_tick  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_presc <= w_presc_nxt;
            r_ctrl  <= w_ctrl_norm;
            r_state <= w_state_nxt;
            r_light <= w_light_nxt;
            r_tick  <= w_tick;
            r_done  <= w_done_nxt;
        end
    end

    assign sys_clk_1s = r_tick;
    assign light_t    = r_light;
    assign phase_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_light_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_light_timer
// Brief    : Directed self-checking bench for light_timer with CLK_DIV = 4
//            and default phase durations (G=10, Y=5, R=15).
// Revision : 1.0 - initial release
// ============================================================================
module tb_light_timer;

    logic        r_clk;
    logic        r_rst;
    logic [2:0]  r_ctrl;
    logic        r_en;
    logic        w_tick;
    logic [3:0]  w_light;
    logic        w_done;

    int          tests;
    int          fails;

    light_timer #(
        .CLK_DIV (4),
        .G_T     (4'd10),
        .Y_T     (4'd5),
        .R_T     (4'd15)
    ) u_dut (
        .sys_clk    (r_clk),
        .sys_rst_n  (r_rst),
        .light_ctrl (r_ctrl),
        .timer_en   (r_en),
        .sys_clk_1s (w_tick),
        .light_t    (w_light),
        .phase_done (w_done)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    // Advance n rising edges, then settle 1 ns past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge r_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        r_rst  = 1'b1;
        r_ctrl = 3'b000;
        r_en   = 1'b1;

        // Reset values
        step(2);
        check("rst_light", 32'(w_light), 32'd1);
        check("rst_tick",  32'(w_tick),  32'd0);
        check("rst_done",  32'(w_done),  32'd0);
        r_rst = 1'b0;

        // IDLE: tick every 4 cycles, expiry with each tick, light_t = 1
        step(3);
        check("idle_pre_tick", 32'(w_tick), 32'd0);
        step(1);
        check("idle_tick1",  32'(w_tick),  32'd1);
        check("idle_done1",  32'(w_done),  32'd1);
        check("idle_light1", 32'(w_light), 32'd1);
        step(1);
        check("idle_tick_clr", 32'(w_tick), 32'd0);
        check("idle_done_clr", 32'(w_done), 32'd0);
        step(3);
        check("idle_tick2", 32'(w_tick), 32'd1);
        check("idle_done2", 32'(w_done), 32'd1);

        // Green: load 10, count down to 1, then expire and reload
        r_ctrl = 3'b001;
        step(1);
        check("g_load",      32'(w_light), 32'd10);
        check("g_load_done", 32'(w_done),  32'd0);
        for (int i = 9; i >= 1; i--) begin
            step(4);
            check("g_count",      32'(w_light), 32'(i));
            check("g_count_tick", 32'(w_tick),  32'd1);
            check("g_count_done", 32'(w_done),  32'd0);
        end
        step(4);
        check("g_done",   32'(w_done),  32'd1);
        check("g_reload", 32'(w_light), 32'd10);

        // Pause at 6 for 20 cycles, then resume
        step(16);
        check("g_six", 32'(w_light), 32'd6);
        r_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("pause_light", 32'(w_light), 32'd6);
            check("pause_tick",  32'(w_tick),  32'd0);
            check("pause_done",  32'(w_done),  32'd0);
        end
        r_en = 1'b1;
        step(3);
        check("resume_hold", 32'(w_light), 32'd6);
        step(1);
        check("resume_dec",  32'(w_light), 32'd5);
        check("resume_tick", 32'(w_tick),  32'd1);

        // Phase change to red coinciding with a tick at light_t = 3
        step(8);
        check("g_three", 32'(w_light), 32'd3);
        step(3);
        r_ctrl = 3'b100;
        step(1);
        check("r_load_win",  32'(w_light), 32'd15);
        check("r_load_tick", 32'(w_tick),  32'd1);
        check("r_load_done", 32'(w_done),  32'd0);

        // Reset in red at light_t = 7
        step(32);
        check("r_seven", 32'(w_light), 32'd7);
        r_rst = 1'b1;
        step(1);
        r_rst = 1'b0;
        check("mid_rst_light", 32'(w_light), 32'd1);
        check("mid_rst_tick",  32'(w_tick),  32'd0);
        check("mid_rst_done",  32'(w_done),  32'd0);
        step(1);
        check("r_after_rst", 32'(w_light), 32'd15);
        step(4);
        check("r_first_tick",  32'(w_tick),  32'd1);
        check("r_first_light", 32'(w_light), 32'd14);

        // Illegal code 011 behaves as IDLE
        r_ctrl = 3'b011;
        step(1);
        check("bad_light", 32'(w_light), 32'd1);
        step(3);
        check("bad_pre_tick", 32'(w_tick), 32'd0);
        step(1);
        check("bad_done1",  32'(w_done),  32'd1);
        check("bad_light1", 32'(w_light), 32'd1);
        step(4);
        check("bad_done2", 32'(w_done), 32'd1);

        // Phase change while paused loads the new duration but stays paused
        r_ctrl = 3'b001;
        step(1);
        check("g2_load", 32'(w_light), 32'd10);
        r_en = 1'b0;
        step(1);
        r_ctrl = 3'b010;
        step(1);
        check("y_pause_load", 32'(w_light), 32'd5);
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("y_pause_light", 32'(w_light), 32'd5);
            check("y_pause_tick",  32'(w_tick),  32'd0);
        end
        r_en = 1'b1;
        step(3);
        check("y_resume_hold", 32'(w_light), 32'd5);
        step(1);
        check("y_resume_dec",  32'(w_light), 32'd4);
        check("y_resume_tick", 32'(w_tick),  32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/light_timer.md
LIGHT_TIMER -- requirements
Module: light_timer

Interface
REQ-001 Parameter CLK_DIV, default 50_000_000, sys_clk cycles per 1 s tick; legal values are 2 and above.
REQ-002 Parameter G_T, default 4'd10, green phase duration in seconds.
REQ-003 Parameter Y_T, default 4'd5, yellow phase duration in seconds.
REQ-004 Parameter R_T, default 4'd15, red phase duration in seconds.
REQ-005 Port sys_clk, input, 1 bit, the single system clock; all logic SHALL be on its rising edge.
REQ-006 Port sys_rst_n, input, 1 bit, reset that is synchronous and active-high despite the suffix.
REQ-007 Port light_ctrl, input, 3 bits, phase request from the traffic-light FSM: 3'b001 = G, 3'b010 = Y, 3'b100 = R, 3'b000 = IDLE.
REQ-008 Port timer_en, input, 1 bit, count enable; when low the block pauses.
REQ-009 Port sys_clk_1s, output, 1 bit, one-sys_clk-cycle pulse once per second.
REQ-010 Port light_t, output, 4 bits, seconds remaining in the current phase; feeds the FSM.
REQ-011 Port phase_done, output, 1 bit, one-cycle pulse marking expiry of the current phase.

Function
REQ-012 A prescaler SHALL count 0 to CLK_DIV-1 while timer_en=1 and wrap to 0.
REQ-013 sys_clk_1s SHALL be registered and SHALL be high for exactly the one cycle after the prescaler reaches CLK_DIV-1.
REQ-014 While timer_en=0, the prescaler and light_t SHALL hold, and sys_clk_1s and phase_done SHALL stay 0.
REQ-015 The block SHALL register light_ctrl each cycle (ctrl_q); a phase change is light_ctrl != ctrl_q.
REQ-016 The phase FSM SHALL have the states ST_IDLE, ST_RUN and ST_PAUSE.
REQ-017 The FSM SHALL go from ST_IDLE to ST_RUN when light_ctrl is G, Y or R and timer_en=1.
REQ-018 The FSM SHALL go from ST_RUN to ST_PAUSE when timer_en=0, and from ST_PAUSE back to ST_RUN when timer_en=1.
REQ-019 The FSM SHALL go from any state to ST_IDLE when light_ctrl is 3'b000.
REQ-020 Any value of light_ctrl other than the four codes in REQ-007 SHALL be treated as IDLE.
REQ-021 On a phase change, the next cycle SHALL load light_t with the duration of the new phase (G_T, Y_T or R_T) and clear the prescaler to 0.
REQ-022 On a tick in ST_RUN with light_t > 1, light_t SHALL decrement by 1 on the same edge that asserts sys_clk_1s.
REQ-023 On a tick in ST_RUN with light_t = 1, phase_done SHALL pulse for one cycle and light_t SHALL reload the current phase duration (auto-repeat until the FSM changes phase).
REQ-024 In ST_IDLE, light_t SHALL equal 4'd1 and phase_done SHALL pulse on every tick, so the FSM can leave its IDLE state.
REQ-025 If a phase change and a tick fall in the same cycle, the load SHALL win: no decrement and no phase_done; the tick SHALL still be output on sys_clk_1s.
REQ-026 A duration parameter of 0 SHALL be treated as 1.
REQ-027 light_t SHALL never be 0 outside reset-free operation, and the decrement SHALL never underflow.
REQ-028 A phase change during ST_PAUSE SHALL load the new duration while light_t stays paused.

Reset
REQ-029 While sys_rst_n=1 at a clock edge, the following SHALL be set: prescaler 0, ctrl_q 3'b000, FSM ST_IDLE, light_t 4'd1, sys_clk_1s 0, phase_done 0.
REQ-030 Reset asserted mid-phase SHALL abort the count with no phase_done pulse.
REQ-031 After reset releases, the first tick SHALL occur CLK_DIV cycles later, given timer_en=1.

Verification (CLK_DIV=4)
REQ-032 Reset, then light_ctrl=000 and timer_en=1 -> sys_clk_1s every 4 cycles, light_t=1, phase_done with each tick.
REQ-033 light_ctrl to 001 -> light_t=10 next cycle, then 9, 8, ... 1 at 4-cycle spacing; the tick after 1 gives phase_done=1 and light_t=10.
REQ-034 In G with light_t=6, drop timer_en for 20 cycles -> light_t stays 6 with no pulses; raise it -> light_t=5 four cycles later.
REQ-035 Switch to 100 in the same cycle as a tick with light_t=3 -> light_t=15, no phase_done, sys_clk_1s still asserted.
REQ-036 Assert sys_rst_n for 1 cycle in R with light_t=7 -> light_t=1, no phase_done, outputs 0, FSM ST_IDLE.
REQ-037 Drive light_ctrl=011 -> behaviour identical to IDLE (light_t=1, phase_done each tick).
